// File: rtl/amstrad_mem_arbiter.sv
// amstrad_mem_arbiter
// Slot-based arbiter for the single SDRAM CPU port of the CPC core.
// One access is issued per ce_ref slot, shared between the boot download
// writer (through a small write FIFO), the Z80 memory interface and a
// secondary DMA requester (snapshot/tape engine).
// Optional build macro ARB_ROM_PROTECT_EN: CPU/DMA writes into ROM space
// (addr[22]=1) are granted and acknowledged but never reach the SDRAM.
module amstrad_mem_arbiter #(
  parameter int FIFO_DEPTH = 4,  // boot write FIFO entries, power of 2, >= 2
  parameter int MAX_WAIT   = 3   // slots DMA may lose to CPU; 0 = no force-grant
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,

  input  logic        boot_active,
  input  logic        boot_wr,
  input  logic [22:0] boot_addr,
  input  logic [1:0]  boot_bank,
  input  logic [7:0]  boot_data,
  output logic        boot_full,
  output logic        boot_ovf,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [22:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,

  input  logic        model,

  output logic        sd_oe,
  output logic        sd_we,
  output logic [22:0] sd_addr,
  output logic [1:0]  sd_bank,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_BOOT,
    GRANT_CPU,
    GRANT_DMA
  } grant_t;

  typedef struct packed {
    logic [1:0]  bank;
    logic [22:0] addr;
    logic [7:0]  data;
  } boot_entry_t;

  // ---------------------------------------------------------------------
  // Boot write FIFO
  // ---------------------------------------------------------------------
  boot_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               boot_pop;
  logic               boot_push;
  boot_entry_t        fifo_head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign boot_full  = fifo_full;

  // A pop in the same cycle frees the head entry, so a push into a full
  // FIFO is still accepted when the slot is draining it.
  assign boot_pop  = ce_ref & boot_active & ~fifo_empty;
  assign boot_push = boot_wr & (~fifo_full | boot_pop);

  // FIFO pointers and the sticky overflow flag.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      boot_ovf <= 1'b0;
    end else begin
      if (boot_push) wr_ptr <= wr_ptr + 1'b1;
      if (boot_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (boot_wr && fifo_full && !boot_pop) boot_ovf <= 1'b1;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk_sys) begin
    if (boot_push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{bank: boot_bank, addr: boot_addr, data: boot_data};
    end
  end

  // ---------------------------------------------------------------------
  // Slot arbitration
  // ---------------------------------------------------------------------
  grant_t             grant;
  logic               grant_we;
  logic [WAIT_W-1:0]  wait_cnt;
  grant_t             next_grant;
  logic               cpu_elig;
  logic               dma_elig;
  logic               force_dma;
  logic               cpu_block;
  logic               dma_block;

  // Choose the requester for the upcoming slot and the ROM-space write mask.
  // NOTE: every signal driven here gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    next_grant = GRANT_NONE;
    cpu_elig   = cpu_req & ~cpu_ack;
    dma_elig   = dma_req & ~dma_ack;
    force_dma  = (MAX_WAIT != 0) && dma_elig && (wait_cnt >= WAIT_LIMIT);

    if (boot_active) begin
      if (!fifo_empty) next_grant = GRANT_BOOT;
    end else if (force_dma) begin
      next_grant = GRANT_DMA;
    end else if (cpu_elig) begin
      next_grant = GRANT_CPU;
    end else if (dma_elig) begin
      next_grant = GRANT_DMA;
    end

`ifdef ARB_ROM_PROTECT_EN
    cpu_block = cpu_we & cpu_addr[22];
    dma_block = dma_we & dma_addr[22];
`else
    cpu_block = 1'b0;
    dma_block = 1'b0;
`endif
  end

  // Slot FSM: on each ce_ref retire the previous grant, then latch the new
  // grant's SDRAM command for the whole slot; acks are one-cycle pulses.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      grant     <= GRANT_NONE;
      grant_we  <= 1'b0;
      wait_cnt  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      sd_oe     <= 1'b0;
      sd_we     <= 1'b0;
      sd_addr   <= '0;
      sd_bank   <= '0;
      sd_din    <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;

      if (ce_ref) begin
        // Retire the access issued during the slot that is ending now.
        unique case (grant)
          GRANT_CPU: begin
            cpu_ack <= 1'b1;
            if (!grant_we) cpu_rdata <= sd_dout;
          end
          GRANT_DMA: begin
            dma_ack <= 1'b1;
            if (!grant_we) dma_rdata <= sd_dout;
          end
          GRANT_BOOT, GRANT_NONE: ;
        endcase

        grant <= next_grant;

        // Issue the access for the slot that starts now.
        unique case (next_grant)
          GRANT_BOOT: begin
            grant_we <= 1'b1;
            sd_we    <= 1'b1;
            sd_oe    <= 1'b0;
            sd_addr  <= fifo_head.addr;
            sd_bank  <= fifo_head.bank;
            sd_din   <= fifo_head.data;
          end
          GRANT_CPU: begin
            grant_we <= cpu_we;
            sd_we    <= cpu_we & ~cpu_block;
            sd_oe    <= ~cpu_we;
            sd_addr  <= cpu_addr;
            sd_bank  <= {1'b0, model};
            sd_din   <= cpu_din;
          end
          GRANT_DMA: begin
            grant_we <= dma_we;
            sd_we    <= dma_we & ~dma_block;
            sd_oe    <= ~dma_we;
            sd_addr  <= dma_addr;
            sd_bank  <= {1'b0, model};
            sd_din   <= dma_din;
          end
          GRANT_NONE: begin
            grant_we <= 1'b0;
            sd_we    <= 1'b0;
            sd_oe    <= 1'b0;
          end
        endcase

        // Count slots DMA has been kept waiting; saturate at the limit.
        if (!dma_req || next_grant == GRANT_DMA) begin
          wait_cnt <= '0;
        end else if (wait_cnt < WAIT_LIMIT) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule
